bus_arb4: RTL and testbench
===========================

# bus_arb4

Round-robin arbiter and sequencer that shares one 32-bit bus port between four requesters (e.g. IF, MEM, DMA, debug). It drives the 2-bit select of the shared 4:1 32-bit data/address mux. It holds each grant until the slave signals completion, and it aborts hung transfers with a timeout. It sits between the requesting units and the memory/peripheral port in the CPU top level.

## Interface
- TIMEOUT, 255: maximum cycles a grant may remain in BUSY without `slv_done` (1..255).
- CW, 8: timeout counter width; TIMEOUT must fit in CW bits.

- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester, level; req[i] held until its grant ends.
- slv_done  in  1  one-cycle completion pulse from the slave.
- gnt  out  4  one-hot grant, registered; all zero when idle.
- sel  out  2  mux select = index of the current or last grantee, registered.
- bus_valid  out  1  high while a grant is active (BUSY).
- err  out  1  one-cycle pulse on timeout abort.
- busy  out  1  equals bus_valid; kept separate for the hazard unit.

## Operation
- Reset (async assert) values: gnt=0, sel=0, bus_valid=0, busy=0, err=0, ptr=0, cnt=0, state=IDLE.
- States: IDLE, BUSY.
- IDLE handling:
  - If req≠0, pick the first set bit scanning ptr, ptr+1, … mod 4.
  - Next edge: gnt=onehot(pick), sel=pick, cnt=0, state goes to BUSY.
  - If req=0, stay in IDLE; sel holds its last value so the mux output stays stable.
- BUSY handling:
  - gnt, sel and bus_valid stay constant; cnt increments each cycle.
  - slv_done=1: next edge gnt=0, ptr=sel+1 (mod 4, wraps 3 to 0), state goes to IDLE.
  - slv_done=0 and cnt==TIMEOUT−1: next edge gnt=0, err=1 for one cycle, ptr=sel+1, state goes to IDLE.
  - slv_done and timeout in the same cycle: done wins, err stays 0.
  - The granted requester dropping req during BUSY is ignored; the grant holds until done or timeout.
  - Changes on non-granted req bits have no effect until IDLE.
- slv_done in IDLE is ignored.
- Reset mid-transfer: all outputs clear immediately. After release, arbitration restarts from ptr=0.

## Timing
- Request latency: req sampled in IDLE at edge N gives gnt/bus_valid at edge N+1.
- Release: slv_done at edge M gives gnt=0 at M+1. A new grant comes no earlier than M+2, so there is one idle turnaround cycle.
- Timeout: grant at edge G with no done gives err=1 and gnt=0 at edge G+TIMEOUT. err is 0 again at G+TIMEOUT+1.
- Fairness: a continuously asserted req waits at most 3 full grants.
- All outputs are registered. There is no combinational path from req/slv_done to any output.

## Structure
- Shared package `arb_pkg` holds:
  - state enum ARB_IDLE=1'b0, ARB_BUSY=1'b1;
  - NREQ=4;
  - default TIMEOUT constant.
- Sub-module `rr_pick4`: combinational; inputs req[3:0] and ptr[1:0]; outputs pick[1:0] and any.
  - It rotates req by ptr, runs a priority encode, then rotates back.
- Top-level logic is the FSM, the counter, the ptr register and the output registers.

## Test plan
- Reset, then req=4'b0100 → gnt=4'b0100 and sel=2 one cycle later. slv_done 3 cycles later → gnt=0 next cycle, ptr=3.
- req=4'b1111 held, slv_done 2 cycles after each grant, from reset → grant order 0,1,2,3,0 and sel follows. Each grant is separated by one idle cycle.
- Set TIMEOUT=5, req=4'b0010, no slv_done → gnt=4'b0010 for exactly 5 cycles, then err=1 for 1 cycle, gnt=0, ptr=2.
- Set TIMEOUT=5, slv_done on the 5th BUSY cycle → done wins, err stays 0, normal release.
- Grant to 3, then slv_done with req=4'b1001 → ptr wraps to 0 and the next gnt=4'b0001.
- rst_n pulsed low mid-BUSY with gnt=4'b1000 → gnt, sel, bus_valid and err are 0 asynchronously. After release with req=4'b1000, the grant resumes with ptr=0 and sel=3 one cycle later.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the four-way bus arbiter.
package arb_pkg;
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;
    localparam int NREQ        = 4;
    localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotating priority pick of the first set request at or after ptr.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      pick,
    output logic            any
);
    logic [NREQ-1:0] rot;
    logic [1:0]      idx;
    // rotate so the ptr requester sits at bit 0, encode, then rotate the index back
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        idx = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    end
    assign pick = idx + ptr;
    assign any  = |req;
endmodule

// File: rtl/bus_arb4.sv
// bus_arb4: round-robin grant sequencer for one shared bus port with timeout abort.
module bus_arb4
    import arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            slv_done,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            bus_valid,
    output logic            err,
    output logic            busy
);
    arb_state_t      state, state_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [1:0]      sel_nx, ptr, ptr_nx, pick;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            err_nx, any, timeout;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    assign timeout = cnt == CW'(TIMEOUT - 1);

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        sel_nx   = sel;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        if (state == ARB_IDLE) begin
            if (any) begin
                state_nx = ARB_BUSY;
                gnt_nx   = NREQ'(1) << pick;
                sel_nx   = pick;
                cnt_nx   = '0;
            end
        end else if (slv_done || timeout) begin
            // completion takes precedence, so err only fires on a genuine abort
            state_nx = ARB_IDLE;
            gnt_nx   = '0;
            ptr_nx   = sel + 2'd1;
            err_nx   = !slv_done;
        end else begin
            cnt_nx = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
        end
    end

    assign bus_valid = state == ARB_BUSY;
    assign busy      = bus_valid;
endmodule

// File: tb/tb_bus_arb4.sv
// tb_bus_arb4: directed and randomized checks of bus_arb4 against a behavioural model.
module tb_bus_arb4;
    import arb_pkg::*;
    localparam int TO = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       slv_done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_valid, err, busy;

    int vectors = 0, miscompares = 0;
    bit m_busy, m_err;
    int m_sel, m_ptr, m_age;

    always #5 clk = ~clk;

    bus_arb4 #(.TIMEOUT(TO), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .slv_done  (slv_done),
        .gnt       (gnt),
        .sel       (sel),
        .bus_valid (bus_valid),
        .err       (err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".gnt"}, gnt, m_busy ? 4'(1 << m_sel) : 4'b0);
        check({tag, ".sel"}, {2'b0, sel}, 4'(m_sel));
        check({tag, ".bus_valid"}, {3'b0, bus_valid}, {3'b0, m_busy});
        check({tag, ".busy"}, {3'b0, busy}, {3'b0, m_busy});
        check({tag, ".err"}, {3'b0, err}, {3'b0, m_err});
    endtask

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_sel = 0; m_ptr = 0; m_age = 0;
    endtask

    // age counts the edges the grant has been visible; abort once it reaches TO
    task automatic model_edge();
        bit found;
        found = 0;
        m_err = 0;
        if (m_busy) begin
            if (slv_done) begin
                m_busy = 0; m_ptr = (m_sel + 1) % 4;
            end else if (m_age == TO) begin
                m_busy = 0; m_err = 1; m_ptr = (m_sel + 1) % 4;
            end else m_age++;
        end else begin
            for (int k = 0; k < 4; k++)
                if (!found && req[(m_ptr + k) % 4]) begin
                    found = 1; m_busy = 1; m_sel = (m_ptr + k) % 4; m_age = 1;
                end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [3:0] r, input logic d);
        req = r; slv_done = d;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(4'b0, 1'b0);
        do_reset("reset");

        drive(4'b0100, 1'b0);
        step("t1_grant");
        check("t1_gnt_const", gnt, 4'b0100);
        step("t1_b1");
        step("t1_b2");
        drive(4'b0100, 1'b1);
        step("t1_rel");
        check("t1_rel_const", gnt, 4'b0000);
        drive(4'b1111, 1'b0);
        step("t1_ptr3");
        check("t1_ptr3_const", gnt, 4'b1000);

        do_reset("t2_reset");
        drive(4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("t2_grant");
            check("t2_order", gnt, 4'(1 << (i % 4)));
            step("t2_b1");
            drive(4'b1111, 1'b1);
            step("t2_rel");
            check("t2_idle", {3'b0, bus_valid}, 4'b0);
            drive(4'b1111, 1'b0);
        end

        do_reset("t3_reset");
        drive(4'b0010, 1'b0);
        step("t3_grant");
        for (int i = 1; i < TO; i++) step("t3_hold");
        check("t3_hold_const", gnt, 4'b0010);
        step("t3_abort");
        check("t3_err_const", {3'b0, err}, 4'b0001);
        drive(4'b0111, 1'b0);
        step("t3_ptr2");
        check("t3_ptr2_const", gnt, 4'b0100);
        check("t3_err_clear", {3'b0, err}, 4'b0);

        do_reset("t4_reset");
        drive(4'b0001, 1'b0);
        step("t4_grant");
        for (int i = 1; i < TO; i++) step("t4_hold");
        drive(4'b0001, 1'b1);
        step("t4_done_wins");
        check("t4_no_err", {3'b0, err}, 4'b0);
        drive(4'b0000, 1'b0);
        step("t4_idle");

        do_reset("t5_reset");
        drive(4'b1000, 1'b0);
        step("t5_grant3");
        drive(4'b1001, 1'b1);
        step("t5_rel");
        drive(4'b1001, 1'b0);
        step("t5_wrap");
        check("t5_wrap_const", gnt, 4'b0001);

        do_reset("t6_reset");
        drive(4'b1000, 1'b0);
        step("t6_grant3");
        step("t6_b1");
        do_reset("t6_mid_reset");
        check("t6_zero_const", gnt, 4'b0000);
        step("t6_regrant");
        check("t6_sel3", {2'b0, sel}, 4'd3);

        for (int i = 0; i < 1500; i++) begin
            drive(4'($urandom), $urandom_range(0, ((i / 100) % 2) ? 15 : 2) == 0);
            if (i % 500 == 499) do_reset("rnd_reset");
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
